i2s_tx: RTL and testbench
=========================

Name: i2s_tx

Overview:
- Synthesizable I2S master transmitter. Generates bck/lrck from the system clock and serializes stereo 24-bit samples in Philips I2S format, 64 bck per frame, two 32-bit slots per frame.
- Opposite end of the fft_master I2S receive path (sd_in/bck_i/lrck_i). Used as an on-board stimulus source and for loopback test of the FFT chain in place of the microphone.

Parameters:
- CLK_DIV, 4, clk cycles per bck half-period. Must be ≥2. bck period = 2*CLK_DIV clk.
- SAMPLE_W, 24, sample width in bits. Must be ≤ SLOT_W-1.
- SLOT_W, 32, bck per channel slot. The frame is 2*SLOT_W bck.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous reset, active-low
- sample_l  in  SAMPLE_W  left sample, two's complement
- sample_r  in  SAMPLE_W  right sample
- sample_valid  in  1  sample pair offered
- sample_ready  out  1  pair accepted when valid & ready on a clk edge
- bck_o  out  1  I2S bit clock
- lrck_o  out  1  word select: 0 = left, 1 = right
- sd_o  out  1  serial data, MSB first
- frame_start  out  1  1-clk pulse when a new frame's shift register loads
- underrun  out  1  1-clk pulse when a frame loads with no pending pair

Behaviour:
- Reset (async assert, sync release): bck_o=0, lrck_o=0, sd_o=0, frame_start=0, underrun=0, div_cnt=0, bit_cnt=0, buffer empty, so sample_ready=1. Shift register = 0.
- Divider: div_cnt counts 0..CLK_DIV-1. When div_cnt==CLK_DIV-1, bck_o toggles and div_cnt wraps.
- A "fall event" is the clk edge on which bck_o goes 1→0. All of lrck_o, sd_o and bit_cnt update only on fall events, so the receiver samples on bck rising edges.
- bit_cnt is 0..2*SLOT_W-1 and wraps to 0. After each fall event, lrck_o = (bit_cnt ≥ SLOT_W).
- Slot bit p = bit_cnt mod SLOT_W:
  - p=0 drives 0. This is the Philips one-bck delay; the previous slot's pad is also 0.
  - p=1..SAMPLE_W drives sample bits MSB..LSB.
  - p>SAMPLE_W drives 0.
- Frame load happens on the fall event where bit_cnt wraps 63→0, and on the first fall event after reset.
  - If the buffer is full: load {L,R} into the shift register, empty the buffer, pulse frame_start.
  - If the buffer is empty: load zeros, pulse frame_start and underrun together.
- Buffer: one entry (L,R). sample_ready = !full | load_now.
  - Accept and load on the same edge: the old pair moves to the shift register and the new pair is stored, leaving the buffer full.
  - Inputs are sampled only on an accepting edge.
- Latency: a pair accepted during frame N appears starting at frame N+1. Its MSB is on sd_o at the fall event with bit_cnt=1.
- Throughput: one pair per 2*SLOT_W*2*CLK_DIV clk (512 clk at defaults).
- reset_n low mid-frame: all outputs go to reset values immediately and the pending pair is discarded.
- sample_valid held with the buffer full: ready=0 until the next load. No data is lost.

Optional Feature:
- Macro I2S_TX_TONE_EN.
- When defined: internal ramp generator replaces sample_l/sample_r. Both channels carry the ramp value, which starts at 24'h200000 after reset and adds 24'h010000 (wrapping mod 2^24) at each frame load. sample_ready=0 and underrun never pulses. Sample ports remain but are ignored.
- When not defined: no generator logic is built, and the block behaves as described above.

Decomposition:
- Package i2s_pkg holds:
  - localparams I2S_SAMPLE_W=24, I2S_SLOT_W=32, I2S_FRAME_BCK=64;
  - typedef i2s_pair_t (struct: left, right [23:0]).
  The receiver side shares this package.
- One natural sub-module: i2s_clkgen (divider plus bck/lrck/bit_cnt, exports fall_evt and frame_wrap). i2s_tx holds the buffer, shift register and flags.

Test Plan:
- Reset: hold reset_n=0 for 100 clk → bck_o=lrck_o=sd_o=0, sample_ready=1. After release, first bck rise at clk 4 (CLK_DIV=4).
- Single pair: L=24'hA5A5A5, R=24'h123456 before the first load → receiver checker decodes L=A5A5A5, R=123456. lrck low for bits 0-31, MSB at bit_cnt=1, bits 25-31 zero. frame_start pulses once per 512 clk.
- Back-to-back: stream 8 pairs with valid held high → all 8 decoded in order, no underrun, ready drops for the intervening frame while the buffer is full.
- Underrun: no valid after one pair → next frame decodes L=R=0 with an underrun pulse coincident with frame_start.
- Reset mid-frame: assert reset_n at bit_cnt=40 with the buffer full → outputs clear within the same clk. After release, the first frame is an underrun frame of zeros.
- I2S_TX_TONE_EN build: decode 4 frames → 200000, 210000, 220000, 230000 on both channels. sample_ready stays 0.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared I2S definitions used by both the transmit and receive sides.
package i2s_pkg;

  localparam int I2S_SAMPLE_W  = 24;
  localparam int I2S_SLOT_W    = 32;
  localparam int I2S_FRAME_BCK = 64;

  // One stereo sample pair as it travels between producer and serializer.
  typedef struct packed {
    logic [23:0] left;
    logic [23:0] right;
  } i2s_pair_t;

endpackage

// File: rtl/i2s_clkgen.sv
// I2S bit-clock generator: divides clk down to bck, keeps the frame bit
// position and drives the word-select line.  Everything downstream keys
// off fall_evt (bck 1->0) so the receiver can sample on bck rising edges.
// frame_wrap marks the fall event that starts a new frame; the very first
// fall event after reset also counts as one so the first frame begins at
// bit 0 instead of bit 1.
module i2s_clkgen
  import i2s_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int SLOT_W  = I2S_SLOT_W
) (
  input  logic clk,
  input  logic reset_n,
  output logic bck_o,
  output logic lrck_o,
  output logic fall_evt,
  output logic frame_wrap
);

  localparam int DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int FRAME_BITS = 2 * SLOT_W;
  localparam int BIT_W      = $clog2(FRAME_BITS);

  localparam logic [DIV_W-1:0] DIV_LAST     = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST     = BIT_W'(FRAME_BITS - 1);
  localparam logic [BIT_W-1:0] RIGHT_FIRST  = BIT_W'(SLOT_W);

  logic [DIV_W-1:0] div_cnt_reg;
  logic             bck_reg;
  logic [BIT_W-1:0] bit_cnt_reg;
  logic [BIT_W-1:0] bit_cnt_next;
  logic             lrck_reg;
  logic             started_reg;
  logic             div_wrap;

  assign div_wrap   = (div_cnt_reg == DIV_LAST);
  assign fall_evt   = div_wrap & bck_reg;
  assign frame_wrap = fall_evt & (~started_reg | (bit_cnt_reg == BIT_LAST));

  assign bck_o  = bck_reg;
  assign lrck_o = lrck_reg;

  // Next frame bit position: hold at 0 on the first fall, wrap at end of frame.
  always_comb begin
    bit_cnt_next = bit_cnt_reg + BIT_W'(1);
    if (!started_reg || (bit_cnt_reg == BIT_LAST)) begin
      bit_cnt_next = '0;
    end
  end

  // Half-period divider; bck toggles each time the divider wraps.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt_reg <= '0;
      bck_reg     <= 1'b0;
    end else if (div_wrap) begin
      div_cnt_reg <= '0;
      bck_reg     <= ~bck_reg;
    end else begin
      div_cnt_reg <= div_cnt_reg + DIV_W'(1);
    end
  end

  // Bit position and word select advance only on bck falling edges.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt_reg <= '0;
      lrck_reg    <= 1'b0;
      started_reg <= 1'b0;
    end else if (fall_evt) begin
      bit_cnt_reg <= bit_cnt_next;
      lrck_reg    <= (bit_cnt_next >= RIGHT_FIRST);
      started_reg <= 1'b1;
    end
  end

endmodule

// File: rtl/i2s_tx.sv
// I2S master transmitter, Philips format, two SLOT_W-bit slots per frame.
// A one-entry pair buffer sits in front of a frame-wide shift register that
// is reloaded at every frame boundary; an empty buffer at that moment sends
// a frame of zeros and flags underrun.
// Build option: define I2S_TX_TONE_EN to replace the sample inputs with an
// internal ramp (both channels equal, +0x010000 per frame, starting at
// 0x200000); the input handshake is then unused and sample_ready stays low.
module i2s_tx
  import i2s_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int SAMPLE_W = I2S_SAMPLE_W,
  parameter int SLOT_W   = I2S_SLOT_W
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [SAMPLE_W-1:0] sample_l,
  input  logic [SAMPLE_W-1:0] sample_r,
  input  logic                sample_valid,
  output logic                sample_ready,
  output logic                bck_o,
  output logic                lrck_o,
  output logic                sd_o,
  output logic                frame_start,
  output logic                underrun
);

  localparam int FRAME_BITS = 2 * SLOT_W;

  logic                  fall_evt;
  logic                  frame_wrap;
  logic [SAMPLE_W-1:0]   src_l;
  logic [SAMPLE_W-1:0]   src_r;
  logic                  load_empty;
  logic [FRAME_BITS-1:0] frame_img;
  logic [FRAME_BITS-1:0] shift_reg;
  logic                  sd_reg;
  logic                  frame_start_reg;
  logic                  underrun_reg;

  i2s_clkgen #(
    .CLK_DIV (CLK_DIV),
    .SLOT_W  (SLOT_W)
  ) u_clkgen (
    .clk        (clk),
    .reset_n    (reset_n),
    .bck_o      (bck_o),
    .lrck_o     (lrck_o),
    .fall_evt   (fall_evt),
    .frame_wrap (frame_wrap)
  );

`ifdef I2S_TX_TONE_EN

  localparam logic [SAMPLE_W-1:0] RAMP_INIT = SAMPLE_W'(24'h200000);
  localparam logic [SAMPLE_W-1:0] RAMP_STEP = SAMPLE_W'(24'h010000);

  logic [SAMPLE_W-1:0] ramp_reg;
  logic                unused_inputs;

  assign unused_inputs = ^{sample_l, sample_r, sample_valid};
  assign sample_ready  = 1'b0;
  assign load_empty    = 1'b0;
  assign src_l         = ramp_reg;
  assign src_r         = ramp_reg;

  // Ramp steps once per frame, after its current value has been loaded.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ramp_reg <= RAMP_INIT;
    end else if (frame_wrap) begin
      ramp_reg <= ramp_reg + RAMP_STEP;
    end
  end

`else

  logic                buf_full_reg;
  logic [SAMPLE_W-1:0] buf_l_reg;
  logic [SAMPLE_W-1:0] buf_r_reg;
  logic                accept;

  // A frame load frees the entry on the same edge, so a new pair can be
  // taken while the old one moves into the shift register.
  assign sample_ready = ~buf_full_reg | frame_wrap;
  assign accept       = sample_valid & sample_ready;
  assign load_empty   = ~buf_full_reg;
  assign src_l        = buf_full_reg ? buf_l_reg : '0;
  assign src_r        = buf_full_reg ? buf_r_reg : '0;

  // One-entry pair buffer; inputs are captured only on an accepting edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buf_full_reg <= 1'b0;
      buf_l_reg    <= '0;
      buf_r_reg    <= '0;
    end else begin
      if (accept) begin
        buf_full_reg <= 1'b1;
        buf_l_reg    <= sample_l;
        buf_r_reg    <= sample_r;
      end else if (frame_wrap) begin
        buf_full_reg <= 1'b0;
      end
    end
  end

`endif

  // Frame image, MSB = frame bit 0.  Slot bit 0 is the one-bck Philips
  // delay, bits 1..SAMPLE_W carry the sample MSB first, the rest is padding.
  for (genvar gi = 0; gi < FRAME_BITS; gi++) begin : g_img
    localparam int P = gi % SLOT_W;
    if ((P >= 1) && (P <= SAMPLE_W)) begin : g_data
      if (gi >= SLOT_W) begin : g_right
        assign frame_img[FRAME_BITS-1-gi] = src_r[SAMPLE_W-P];
      end else begin : g_left
        assign frame_img[FRAME_BITS-1-gi] = src_l[SAMPLE_W-P];
      end
    end else begin : g_pad
      assign frame_img[FRAME_BITS-1-gi] = 1'b0;
    end
  end

  assign sd_o        = sd_reg;
  assign frame_start = frame_start_reg;
  assign underrun    = underrun_reg;

  // Serializer: reload on frame wrap, otherwise shift one bit per bck fall.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_reg <= '0;
      sd_reg    <= 1'b0;
    end else if (fall_evt) begin
      if (frame_wrap) begin
        sd_reg    <= frame_img[FRAME_BITS-1];
        shift_reg <= {frame_img[FRAME_BITS-2:0], 1'b0};
      end else begin
        sd_reg    <= shift_reg[FRAME_BITS-1];
        shift_reg <= {shift_reg[FRAME_BITS-2:0], 1'b0};
      end
    end
  end

  // Single-cycle status pulses following each frame load.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_start_reg <= 1'b0;
      underrun_reg    <= 1'b0;
    end else begin
      frame_start_reg <= frame_wrap;
      underrun_reg    <= frame_wrap & load_empty;
    end
  end

endmodule

// File: tb/tb_i2s_tx.sv
// Bench for i2s_tx: decodes the I2S stream on bck rising edges and checks
// it against a scoreboard of pairs accepted through the handshake.
// Build with +define+I2S_TX_TONE_EN to exercise the ramp generator build.
module tb_i2s_tx;
  import i2s_pkg::*;

  localparam int CLK_DIV   = 4;
  localparam int FRAME_CLK = I2S_FRAME_BCK * 2 * CLK_DIV;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [23:0] sample_l = '0;
  logic [23:0] sample_r = '0;
  logic        sample_valid = 1'b0;
  logic        sample_ready;
  logic        bck_o;
  logic        lrck_o;
  logic        sd_o;
  logic        frame_start;
  logic        underrun;

  always #5 clk = ~clk;

  i2s_tx #(
    .CLK_DIV  (CLK_DIV),
    .SAMPLE_W (I2S_SAMPLE_W),
    .SLOT_W   (I2S_SLOT_W)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .sample_l     (sample_l),
    .sample_r     (sample_r),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .bck_o        (bck_o),
    .lrck_o       (lrck_o),
    .sd_o         (sd_o),
    .frame_start  (frame_start),
    .underrun     (underrun)
  );

  int n_cmp = 0;
  int n_err = 0;

  i2s_pair_t   acc_q[$];
  i2s_pair_t   exp_q[$];
  logic        pend_acc = 1'b0;
  i2s_pair_t   pend_pair;
  logic [63:0] frame_bits;
  int          fb = 0;
  bit          armed = 0;
  bit          prev_bck = 0;
  bit          have_fs = 0;
  int          cyc = 0;
  int          last_fs = 0;
  int          frames_done = 0;
  int          fs_cnt = 0;
  int          ur_cnt = 0;
  i2s_pair_t   last_dec = '0;
  logic [23:0] ramp_exp = 24'h200000;

  // Receiver and scoreboard, sampled away from the active clk edge.
  always @(negedge clk) begin
    if (!reset_n) begin
      acc_q.delete();
      exp_q.delete();
      pend_acc = 1'b0;
      armed    = 0;
      fb       = 0;
      prev_bck = 0;
      have_fs  = 0;
      cyc      = 0;
      ramp_exp = 24'h200000;
    end else begin
      cyc++;
      if (armed && bck_o && !prev_bck && fb < 64) begin
        logic exp_lr;
        exp_lr = (fb >= 32);
        frame_bits[63-fb] = sd_o;
        n_cmp++;
        if (lrck_o !== exp_lr) begin
          n_err++;
          $display("FAIL lrck at frame bit %0d: got %b want %b", fb, lrck_o, exp_lr);
        end
        fb++;
        if (fb == 64) begin
          i2s_pair_t got;
          i2s_pair_t want;
          got.left  = frame_bits[62:39];
          got.right = frame_bits[30:7];
          n_cmp++;
          if ({frame_bits[63], frame_bits[38:31], frame_bits[6:0]} !== 16'h0) begin
            n_err++;
            $display("FAIL pad bits: got %h want 0000",
                     {frame_bits[63], frame_bits[38:31], frame_bits[6:0]});
          end
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL frame decode: got L=%h R=%h want none", got.left, got.right);
          end else begin
            want = exp_q.pop_front();
            if (got !== want) begin
              n_err++;
              $display("FAIL frame decode: got L=%h R=%h want L=%h R=%h",
                       got.left, got.right, want.left, want.right);
            end
          end
          last_dec = got;
          frames_done++;
          $display("frame %0d decoded L=%h R=%h", frames_done, got.left, got.right);
        end
      end
      prev_bck = bck_o;

      if (underrun) begin
        n_cmp++;
        if (!frame_start) begin
          n_err++;
          $display("FAIL underrun without frame_start: got fs=%b want 1", frame_start);
        end
      end

      if (frame_start) begin
        logic exp_ur;
        fs_cnt++;
        n_cmp++;
        if (have_fs) begin
          if (cyc - last_fs != FRAME_CLK) begin
            n_err++;
            $display("FAIL frame period: got %0d want %0d", cyc - last_fs, FRAME_CLK);
          end
        end else if (cyc != 2 * CLK_DIV) begin
          n_err++;
          $display("FAIL first load clk: got %0d want %0d", cyc, 2 * CLK_DIV);
        end
        if (armed) begin
          n_cmp++;
          if (fb != 64) begin
            n_err++;
            $display("FAIL bits per frame: got %0d want 64", fb);
          end
        end
`ifdef I2S_TX_TONE_EN
        exp_ur = 1'b0;
        exp_q.push_back({ramp_exp, ramp_exp});
        ramp_exp = ramp_exp + 24'h010000;
`else
        exp_ur = (acc_q.size() == 0);
        if (exp_ur) exp_q.push_back('0);
        else        exp_q.push_back(acc_q.pop_front());
`endif
        n_cmp++;
        if (underrun !== exp_ur) begin
          n_err++;
          $display("FAIL underrun at load: got %b want %b", underrun, exp_ur);
        end
        if (underrun) ur_cnt++;
        have_fs = 1;
        last_fs = cyc;
        armed   = 1;
        fb      = 0;
      end

      if (pend_acc) acc_q.push_back(pend_pair);
      pend_acc  = sample_valid && sample_ready;
      pend_pair = {sample_l, sample_r};
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Offer a pair and wait for it to be taken; returns stall cycles.
  task automatic send_pair(input logic [23:0] l, input logic [23:0] r,
                           input bit hold, output int stalls);
    bit taken;
    taken  = 0;
    stalls = 0;
    sample_l = l;
    sample_r = r;
    sample_valid = 1'b1;
    for (int k = 0; k < 4 * FRAME_CLK; k++) begin
      @(negedge clk);
      if (sample_ready) begin
        taken = 1;
        break;
      end
      stalls++;
    end
    if (!taken) begin
      n_cmp++;
      n_err++;
      $display("FAIL send timeout: got ready=0 want 1");
    end
    @(posedge clk);
    #1;
    if (!hold) sample_valid = 1'b0;
    $display("sent L=%h R=%h after %0d stalls", l, r, stalls);
  endtask

  task automatic wait_frames(input int n);
    int target;
    bit done;
    target = frames_done + n;
    done = 0;
    for (int k = 0; k < (n + 2) * FRAME_CLK; k++) begin
      sync();
      if (frames_done >= target) begin
        done = 1;
        break;
      end
    end
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL wait_frames timeout: got %0d want %0d", frames_done, target);
    end
  endtask

  task automatic test_reset();
    logic exp_rdy;
`ifdef I2S_TX_TONE_EN
    exp_rdy = 1'b0;
`else
    exp_rdy = 1'b1;
`endif
    reset_n = 1'b0;
    sample_valid = 1'b0;
    repeat (100) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({bck_o, lrck_o, sd_o, frame_start, underrun} !== 5'b0) begin
      n_err++;
      $display("FAIL reset outputs: got %b want 00000",
               {bck_o, lrck_o, sd_o, frame_start, underrun});
    end
    n_cmp++;
    if (sample_ready !== exp_rdy) begin
      n_err++;
      $display("FAIL reset ready: got %b want %b", sample_ready, exp_rdy);
    end
    #1 reset_n = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      n_cmp++;
      if (bck_o !== (i == 4)) begin
        n_err++;
        $display("FAIL bck after release clk %0d: got %b want %b", i, bck_o, (i == 4));
      end
    end
    $display("reset released");
  endtask

`ifdef I2S_TX_TONE_EN

  task automatic test_tone();
    bit saw_ready;
    saw_ready = 0;
    sample_l = 24'h777777;
    sample_r = 24'h888888;
    sample_valid = 1'b1;
    for (int k = 0; k < 6 * FRAME_CLK; k++) begin
      @(negedge clk);
      if (sample_ready !== 1'b0) saw_ready = 1;
      if (frames_done >= 4) break;
    end
    sample_valid = 1'b0;
    n_cmp++;
    if (saw_ready) begin
      n_err++;
      $display("FAIL tone ready: got 1 want 0");
    end
    n_cmp++;
    if (frames_done != 4 || last_dec !== {24'h230000, 24'h230000}) begin
      n_err++;
      $display("FAIL tone frame 4: got %0d frames L=%h R=%h want 4 frames L=230000 R=230000",
               frames_done, last_dec.left, last_dec.right);
    end
  endtask

`else

  task automatic test_single_pair();
    int st;
    sync();
    send_pair(24'hA5A5A5, 24'h123456, 0, st);
    wait_frames(1);
    n_cmp++;
    if (last_dec !== {24'hA5A5A5, 24'h123456}) begin
      n_err++;
      $display("FAIL single pair: got L=%h R=%h want L=A5A5A5 R=123456",
               last_dec.left, last_dec.right);
    end
  endtask

  task automatic test_back_to_back();
    int st;
    int ur_base;
    bit drained;
    ur_base = 0;
    sync();
    for (int i = 0; i < 8; i++) begin
      send_pair(24'($urandom), 24'($urandom), 1, st);
      if (i == 1) ur_base = ur_cnt;
      if (i >= 2) begin
        n_cmp++;
        if (st != FRAME_CLK - 1) begin
          n_err++;
          $display("FAIL stall while full, pair %0d: got %0d want %0d", i, st, FRAME_CLK - 1);
        end
      end
    end
    sample_valid = 1'b0;
    n_cmp++;
    if (ur_cnt != ur_base) begin
      n_err++;
      $display("FAIL underrun during stream: got %0d want %0d", ur_cnt - ur_base, 0);
    end
    drained = 0;
    for (int k = 0; k < 4 * FRAME_CLK; k++) begin
      sync();
      if (!pend_acc && acc_q.size() == 0 && exp_q.size() == 0) begin
        drained = 1;
        break;
      end
    end
    n_cmp++;
    if (!drained) begin
      n_err++;
      $display("FAIL stream drain: got %0d pending want 0", acc_q.size() + exp_q.size());
    end
  endtask

  task automatic test_underrun();
    int ur0;
    int fs0;
    ur0 = ur_cnt;
    fs0 = fs_cnt;
    wait_frames(2);
    n_cmp++;
    if (ur_cnt - ur0 == 0) begin
      n_err++;
      $display("FAIL underrun count: got 0 want >0");
    end
    n_cmp++;
    if (ur_cnt - ur0 != fs_cnt - fs0) begin
      n_err++;
      $display("FAIL underrun per frame: got %0d want %0d", ur_cnt - ur0, fs_cnt - fs0);
    end
    n_cmp++;
    if (last_dec !== '0) begin
      n_err++;
      $display("FAIL underrun data: got L=%h R=%h want 0", last_dec.left, last_dec.right);
    end
  endtask

  task automatic test_reset_mid();
    int st;
    int ur0;
    bit ok;
    sync();
    send_pair(24'h0F0F0F, 24'hFFFFFF, 0, st);
    ok = 0;
    for (int k = 0; k < 3 * FRAME_CLK; k++) begin
      sync();
      if (!pend_acc && acc_q.size() == 0) begin
        ok = 1;
        break;
      end
    end
    send_pair(24'h5A5A5A, 24'h3C3C3C, 0, st);
    ok = 0;
    for (int k = 0; k < 3 * FRAME_CLK; k++) begin
      sync();
      if (fb == 40 && !bck_o) begin
        ok = 1;
        break;
      end
    end
    n_cmp++;
    if (!ok || lrck_o !== 1'b1 || sd_o !== 1'b1) begin
      n_err++;
      $display("FAIL before mid reset: got lrck=%b sd=%b want 1 1", lrck_o, sd_o);
    end
    ur0 = ur_cnt;
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({bck_o, lrck_o, sd_o, frame_start, underrun, sample_ready} !== 6'b000001) begin
      n_err++;
      $display("FAIL mid reset outputs: got %b want 000001",
               {bck_o, lrck_o, sd_o, frame_start, underrun, sample_ready});
    end
    repeat (20) @(posedge clk);
    @(negedge clk);
    #1 reset_n = 1'b1;
    wait_frames(1);
    n_cmp++;
    if (ur_cnt - ur0 < 1 || last_dec !== '0) begin
      n_err++;
      $display("FAIL first frame after reset: got ur=%0d L=%h R=%h want ur>=1 zeros",
               ur_cnt - ur0, last_dec.left, last_dec.right);
    end
  endtask

`endif

  initial begin
    test_reset();
`ifdef I2S_TX_TONE_EN
    test_tone();
`else
    test_single_pair();
    test_back_to_back();
    test_underrun();
    test_reset_mid();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
